tenthirty_ctrl: RTL and testbench
=================================

TENTHIRTY_CTRL -- requirements
Module: tenthirty_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 4: rounds per game, range 1..4.
REQ-002 SHALL have parameter DEALER_STAND, default 16: dealer stops drawing at or above this many half-points (8 points).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port btn_m, input, 1: hit/start; a debounced one-cycle pulse.
REQ-006 SHALL have port btn_r, input, 1: stand; a debounced one-cycle pulse.
REQ-007 SHALL have port card_req, output, 1: request for one card from the card source.
REQ-008 SHALL have port card_vld, input, 1: card source presents card_num.
REQ-009 SHALL have port card_num, input, 4: card rank, 1..13.
REQ-010 SHALL have port player_pts, output, 6: player total in half-points.
REQ-011 SHALL have port dealer_pts, output, 6: dealer total in half-points.
REQ-012 SHALL have port player_cnt, output, 3: player cards this round.
REQ-013 SHALL have port dealer_cnt, output, 3: dealer cards this round.
REQ-014 SHALL have port round, output, 2: current round index, 0-based.
REQ-015 SHALL have port led, output, 3: led[0] dealer win, led[1] player win, led[2] game done.

Function
REQ-016 SHALL implement FSM states IDLE, P_REQ, P_CHK, P_BTN, D_REQ, D_CHK, CMP, RESULT, DONE.
REQ-017 SHALL map card value: ranks 1..10 give 2*rank half-points; ranks 11..13 give 1 half-point; totals are 6-bit unsigned with no saturation.
REQ-018 SHALL hold card_req high throughout P_REQ/D_REQ and low in all other states.
REQ-019 SHALL accept a card on the cycle card_req&&card_vld with card_num in 1..13, add its value to the active total, increment the active count, and deassert card_req on the next edge.
REQ-020 SHALL ignore card_vld while card_req is low, and SHALL keep waiting with card_req high when card_num is 0 or 14..15.
REQ-021 IDLE: on btn_m, SHALL clear totals, counts and led[1:0], then go to P_REQ.
REQ-022 P_CHK (the cycle after player acceptance): player_pts>21 is a bust, SHALL set led[0] and go to RESULT; else player_cnt==5 SHALL go to D_REQ; else go to P_BTN.
REQ-023 P_BTN: btn_r SHALL go to D_REQ; btn_m SHALL go to P_REQ; if both are high in one cycle, btn_r SHALL win.
REQ-024 D_CHK: dealer_pts>21 SHALL set led[1] and go to RESULT; else dealer_pts>=DEALER_STAND or dealer_cnt==5 SHALL go to CMP; else go to D_REQ.
REQ-025 CMP, one cycle: player_pts>dealer_pts SHALL set led[1]; otherwise, including ties, SHALL set led[0]; then go to RESULT.
REQ-026 RESULT: SHALL hold totals and led until btn_m; on btn_m, if round==NUM_ROUNDS-1 SHALL set led[2] and go to DONE; else increment round, clear totals, counts and led[1:0], and go to P_REQ.
REQ-027 DONE: SHALL be terminal; SHALL ignore all inputs and hold outputs until reset.
REQ-028 SHALL ignore btn_m/btn_r in every state except IDLE, P_BTN and RESULT.
REQ-029 SHALL keep led[1:0] one-hot or zero at all times.

Reset
REQ-030 On a clk edge with rst_n low, SHALL enter IDLE with card_req=0, player_pts=0, dealer_pts=0, player_cnt=0, dealer_cnt=0, round=0, led=3'b000.
REQ-031 Reset asserted mid-handshake SHALL drop card_req at that edge, and any card_vld coincident with that edge SHALL be discarded.

Verification
REQ-032 Start with btn_m, deal player 10 then btn_r; dealer is dealt 5 then 4 -> player_pts=20, dealer_pts=18, led=3'b010.
REQ-033 Player is dealt 10, btn_m, then 3 -> player_pts=26, bust in P_CHK, led=3'b001, and no dealer card_req is issued.
REQ-034 Player 13,12,11,1,1 (five cards, 7 half-points) -> automatic transition to D_REQ without btn_r; dealer 9 -> dealer_pts=18 stands, led=3'b001.
REQ-035 Assert card_vld with card_req low, then card_num=0 during card_req -> both ignored, totals unchanged, card_req stays high until a valid card is accepted.
REQ-036 btn_m and btn_r pulsed on the same cycle in P_BTN -> stand taken, next state D_REQ; after four RESULT+btn_m sequences -> round=3 then DONE with led[2]=1.
REQ-037 Pull rst_n low during P_REQ with card_vld high -> next cycle all outputs are at their reset values and the card is not counted.

Source files
------------

// File: rtl/tenthirty_ctrl.sv
// Ten-and-a-half card game controller.
// Player and dealer totals are kept in half-points; face cards count one half-point.
module tenthirty_ctrl #(
    parameter int NUM_ROUNDS   = 4,
    parameter int DEALER_STAND = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_m,
    input  logic       btn_r,
    output logic       card_req,
    input  logic       card_vld,
    input  logic [3:0] card_num,
    output logic [5:0] player_pts,
    output logic [5:0] dealer_pts,
    output logic [2:0] player_cnt,
    output logic [2:0] dealer_cnt,
    output logic [1:0] round,
    output logic [2:0] led
);

    typedef enum logic [3:0] {
        IDLE, P_REQ, P_CHK, P_BTN, D_REQ, D_CHK, CMP, RESULT, DONE
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] pp_q, pp_d, dp_q, dp_d;
    logic [2:0] pc_q, pc_d, dc_q, dc_d;
    logic [1:0] rnd_q, rnd_d;
    logic [2:0] led_q, led_d;

    logic       card_ok;
    logic [5:0] card_val;
    logic       last_rnd;

    assign card_ok  = card_vld && (card_num >= 4'd1) && (card_num <= 4'd13);
    assign card_val = (card_num <= 4'd10) ? {1'b0, card_num, 1'b0} : 6'd1;
    assign last_rnd = (rnd_q == 2'(NUM_ROUNDS - 1));

    // State and datapath registers; reset wins over any coincident card.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pp_q    <= '0;
            dp_q    <= '0;
            pc_q    <= '0;
            dc_q    <= '0;
            rnd_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            pp_q    <= pp_d;
            dp_q    <= dp_d;
            pc_q    <= pc_d;
            dc_q    <= dc_d;
            rnd_q   <= rnd_d;
            led_q   <= led_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (btn_m) state_d = P_REQ;
            P_REQ:  if (card_ok) state_d = P_CHK;
            P_CHK: begin
                if (pp_q > 6'd21)      state_d = RESULT;
                else if (pc_q == 3'd5) state_d = D_REQ;
                else                   state_d = P_BTN;
            end
            P_BTN: begin
                if (btn_r)      state_d = D_REQ;
                else if (btn_m) state_d = P_REQ;
            end
            D_REQ:  if (card_ok) state_d = D_CHK;
            D_CHK: begin
                if (dp_q > 6'd21)
                    state_d = RESULT;
                else if (dp_q >= 6'(DEALER_STAND) || dc_q == 3'd5)
                    state_d = CMP;
                else
                    state_d = D_REQ;
            end
            CMP:    state_d = RESULT;
            RESULT: if (btn_m) state_d = last_rnd ? DONE : P_REQ;
            DONE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Card request, score accumulation and result LEDs.
    always_comb begin
        pp_d     = pp_q;
        dp_d     = dp_q;
        pc_d     = pc_q;
        dc_d     = dc_q;
        rnd_d    = rnd_q;
        led_d    = led_q;
        card_req = (state_q == P_REQ) || (state_q == D_REQ);
        case (state_q)
            IDLE: begin
                if (btn_m) begin
                    pp_d       = '0;
                    dp_d       = '0;
                    pc_d       = '0;
                    dc_d       = '0;
                    led_d[1:0] = 2'b00;
                end
            end
            P_REQ: begin
                if (card_ok) begin
                    pp_d = pp_q + card_val;
                    pc_d = pc_q + 3'd1;
                end
            end
            P_CHK:  if (pp_q > 6'd21) led_d[1:0] = 2'b01;
            D_REQ: begin
                if (card_ok) begin
                    dp_d = dp_q + card_val;
                    dc_d = dc_q + 3'd1;
                end
            end
            D_CHK:  if (dp_q > 6'd21) led_d[1:0] = 2'b10;
            CMP:    led_d[1:0] = (pp_q > dp_q) ? 2'b10 : 2'b01;
            RESULT: begin
                if (btn_m) begin
                    if (last_rnd) begin
                        led_d[2] = 1'b1;
                    end else begin
                        rnd_d      = rnd_q + 2'd1;
                        pp_d       = '0;
                        dp_d       = '0;
                        pc_d       = '0;
                        dc_d       = '0;
                        led_d[1:0] = 2'b00;
                    end
                end
            end
            default: ;
        endcase
    end

    assign player_pts = pp_q;
    assign dealer_pts = dp_q;
    assign player_cnt = pc_q;
    assign dealer_cnt = dc_q;
    assign round      = rnd_q;
    assign led        = led_q;

endmodule

// File: tb/tb_tenthirty_ctrl.sv
// Directed bench for tenthirty_ctrl.
// Expected snapshots are queued when stimulus is driven and popped on observation.
module tb_tenthirty_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_m;
    logic       btn_r;
    logic       card_req;
    logic       card_vld;
    logic [3:0] card_num;
    logic [5:0] player_pts;
    logic [5:0] dealer_pts;
    logic [2:0] player_cnt;
    logic [2:0] dealer_cnt;
    logic [1:0] round;
    logic [2:0] led;

    tenthirty_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_m      (btn_m),
        .btn_r      (btn_r),
        .card_req   (card_req),
        .card_vld   (card_vld),
        .card_num   (card_num),
        .player_pts (player_pts),
        .dealer_pts (dealer_pts),
        .player_cnt (player_cnt),
        .dealer_cnt (dealer_cnt),
        .round      (round),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    pp;
        int    dp;
        int    pc;
        int    dc;
        int    rd;
        int    led;
        int    req;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    int m_pp, m_dp, m_pc, m_dc, m_rd, m_led, m_req;

    function automatic int cval(input int n);
        return (n <= 10) ? 2 * n : 1;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int got, input int want);
        n_vec++;
        assert (got === want)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic snap(input string tag);
        sb.push_back('{tag, m_pp, m_dp, m_pc, m_dc, m_rd, m_led, m_req});
    endtask

    task automatic check_sb();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".pp"}, int'(player_pts), e.pp);
            chk({e.tag, ".dp"}, int'(dealer_pts), e.dp);
            chk({e.tag, ".pc"}, int'(player_cnt), e.pc);
            chk({e.tag, ".dc"}, int'(dealer_cnt), e.dc);
            chk({e.tag, ".rd"}, int'(round), e.rd);
            chk({e.tag, ".led"}, int'(led), e.led);
            chk({e.tag, ".req"}, int'(card_req), e.req);
        end
    endtask

    task automatic model_zero();
        m_pp = 0; m_dp = 0; m_pc = 0; m_dc = 0;
        m_rd = 0; m_led = 0; m_req = 0;
    endtask

    task automatic model_new_round();
        m_pp = 0; m_dp = 0; m_pc = 0; m_dc = 0;
        m_led = m_led & 4;
        m_req = 1;
    endtask

    task automatic pulse_m();
        btn_m = 1'b1;
        tick();
        btn_m = 1'b0;
    endtask

    task automatic pulse_r();
        btn_r = 1'b1;
        tick();
        btn_r = 1'b0;
    endtask

    task automatic give(input bit to_player, input int n, input string tag);
        int k;
        k = 0;
        while (card_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk({tag, ".req_wait"}, int'(card_req), 1);
        card_vld = 1'b1;
        card_num = 4'(n);
        if (to_player) begin
            m_pp += cval(n);
            m_pc += 1;
        end else begin
            m_dp += cval(n);
            m_dc += 1;
        end
        m_req = 0;
        snap(tag);
        tick();
        card_vld = 1'b0;
        card_num = 4'd0;
        check_sb();
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_m    = 1'b0;
        btn_r    = 1'b0;
        card_vld = 1'b0;
        card_num = 4'd0;
        tick();
        tick();
        rst_n = 1'b1;
        model_zero();
        snap("reset");
        check_sb();

        // card_vld without a request is ignored
        card_vld = 1'b1;
        card_num = 4'd5;
        tick();
        card_vld = 1'b0;
        snap("idle_vld");
        check_sb();

        // round 0: player 10 stands, dealer 5+4
        pulse_m();
        m_req = 1;
        snap("start");
        check_sb();
        card_vld = 1'b1;
        card_num = 4'd0;
        tick();
        snap("rank0");
        check_sb();
        card_num = 4'd14;
        tick();
        card_vld = 1'b0;
        card_num = 4'd0;
        snap("rank14");
        check_sb();
        give(1, 10, "p10");
        tick();
        pulse_r();
        m_req = 1;
        snap("stand");
        check_sb();
        give(0, 5, "d5");
        give(0, 4, "d4");
        tick();
        tick();
        m_led = 2;
        snap("pwin");
        check_sb();
        chk("r0_pts", int'(player_pts), 20);
        chk("r0_led", int'(led), 3'b010);

        // round 1: player 10, hit 3, bust
        pulse_m();
        m_rd = 1;
        model_new_round();
        snap("rnd1");
        check_sb();
        give(1, 10, "p10b");
        tick();
        pulse_m();
        give(1, 3, "p3");
        tick();
        m_led = 1;
        snap("pbust");
        check_sb();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_dreq", int'(card_req), 0);
        end

        // round 2: five small cards force the dealer turn
        pulse_m();
        m_rd = 2;
        model_new_round();
        snap("rnd2");
        check_sb();
        give(1, 13, "p13");
        tick();
        pulse_m();
        give(1, 12, "p12");
        tick();
        pulse_m();
        give(1, 11, "p11");
        tick();
        pulse_m();
        give(1, 1, "p1a");
        tick();
        pulse_m();
        give(1, 1, "p1b");
        tick();
        m_req = 1;
        snap("auto_dreq");
        check_sb();
        give(0, 9, "d9");
        tick();
        tick();
        m_led = 1;
        snap("dstand");
        check_sb();

        // round 3: both buttons together means stand
        pulse_m();
        m_rd = 3;
        model_new_round();
        snap("rnd3");
        check_sb();
        give(1, 2, "p2");
        tick();
        btn_m = 1'b1;
        btn_r = 1'b1;
        tick();
        btn_m = 1'b0;
        btn_r = 1'b0;
        m_req = 1;
        snap("both_btn");
        check_sb();
        give(0, 10, "d10");
        tick();
        tick();
        m_led = 1;
        snap("r3_res");
        check_sb();
        pulse_m();
        m_led = 5;
        m_req = 0;
        snap("done");
        check_sb();
        pulse_m();
        pulse_r();
        card_vld = 1'b1;
        card_num = 4'd3;
        tick();
        card_vld = 1'b0;
        card_num = 4'd0;
        snap("done_hold");
        check_sb();

        // reset during a player request with a card on the bus
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_zero();
        snap("rst2");
        check_sb();
        pulse_m();
        m_req = 1;
        snap("start2");
        check_sb();
        card_vld = 1'b1;
        card_num = 4'd7;
        rst_n    = 1'b0;
        tick();
        card_vld = 1'b0;
        card_num = 4'd0;
        rst_n    = 1'b1;
        model_zero();
        snap("rst_mid");
        check_sb();
        tick();
        snap("rst_idle");
        check_sb();

        // dealer bust: 7 then 5
        pulse_m();
        m_req = 1;
        snap("start3");
        check_sb();
        give(1, 1, "p1c");
        tick();
        pulse_r();
        give(0, 7, "d7");
        give(0, 5, "d5b");
        tick();
        m_led = 2;
        snap("dbust");
        check_sb();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
